mole_box_picker: RTL and testbench

//  Parametrised pseudo-random "mole" box selector for the whack-a-mole game.
//  A WIDTH-bit Galois LFSR free-runs every enabled cycle. On request, a small
//  FSM draws a box index in [0, NUM_BOXES-1] by rejection sampling, so the mapping
//  is near-uniform. Optionally it forbids repeating the previous box.
//  The result is held on a valid/ack handshake until game control consumes it.

---
 rtl/mole_box_picker.sv | 180 ++++++++++++++++++
 tb/tb_mole_box_picker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_box_picker.sv
// Whack-a-mole box selector: a free-running Galois LFSR feeds a rejection-sampling
// draw FSM. Each result is held on a valid/ack handshake until it is consumed.
module mole_box_picker #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter logic [WIDTH-1:0] SEED      = 8'h01,
  parameter int               NUM_BOXES = 4,
  parameter bit               NO_REPEAT = 1'b1,
  parameter int               MAX_TRIES = 8,
  localparam int              IDX_W     = $clog2(NUM_BOXES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_in,
  input  logic                 req,
  input  logic                 ack,
  output logic                 valid,
  output logic [IDX_W-1:0]     box_idx,
  output logic [NUM_BOXES-1:0] box_onehot,
  output logic                 fallback,
  output logic [WIDTH-1:0]     lfsr_state
);

  localparam int               BOX_MAX_I  = NUM_BOXES - 1;
  localparam int               TRY_LAST_I = MAX_TRIES - 1;
  localparam logic [IDX_W:0]   BOX_LIMIT  = NUM_BOXES[IDX_W:0];
  localparam logic [IDX_W-1:0] BOX_MAX    = BOX_MAX_I[IDX_W-1:0];
  localparam logic [IDX_W-1:0] IDX_ONE    = 1;
  localparam logic [7:0]       TRY_LAST   = TRY_LAST_I[7:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  genvar gi;

  logic [WIDTH-1:0]     lfsr_reg, lfsr_next, lfsr_step;
  state_t               state_reg, state_next;
  logic [7:0]           tries_reg, tries_next;
  logic [IDX_W-1:0]     box_reg, box_next;
  logic [NUM_BOXES-1:0] onehot_reg, onehot_next;
  logic                 valid_reg, valid_next;
  logic                 fallback_reg, fallback_next;
  logic [IDX_W-1:0]     last_box_reg, last_box_next;
  logic                 last_valid_reg, last_valid_next;

  logic [IDX_W-1:0]     cand;
  logic                 cand_in_range;
  logic                 repeat_hit;
  logic                 accept;
  logic                 last_try;
  logic [IDX_W-1:0]     fallback_box;

  // Galois right-shift step: every tapped bit picks up the bit shifted out of s[0].
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_step
      assign lfsr_step[gi] = lfsr_reg[gi+1] ^ (TAPS[gi] & lfsr_reg[0]);
    end
  endgenerate
  assign lfsr_step[WIDTH-1] = TAPS[WIDTH-1] & lfsr_reg[0];

  always_comb begin
    lfsr_next = lfsr_reg;
    if (seed_load) begin
      lfsr_next = (seed_in == '0) ? SEED : seed_in;
    end else if (enable) begin
      lfsr_next = lfsr_step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  // The candidate comes from the registered state, so it is unaffected by this cycle's step.
  assign cand          = lfsr_reg[IDX_W-1:0];
  assign cand_in_range = {1'b0, cand} < BOX_LIMIT;
  assign repeat_hit    = NO_REPEAT && last_valid_reg && (cand == last_box_reg);
  assign accept        = cand_in_range && !repeat_hit;
  assign last_try      = (tries_reg == TRY_LAST);

  always_comb begin
    fallback_box = '0;
    if (last_valid_reg && (last_box_reg != BOX_MAX)) begin
      fallback_box = last_box_reg + IDX_ONE;
    end
  end

  // State register (with the datapath registers it steers).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      tries_reg      <= '0;
      box_reg        <= '0;
      onehot_reg     <= '0;
      valid_reg      <= 1'b0;
      fallback_reg   <= 1'b0;
      last_box_reg   <= '0;
      last_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tries_reg      <= tries_next;
      box_reg        <= box_next;
      onehot_reg     <= onehot_next;
      valid_reg      <= valid_next;
      fallback_reg   <= fallback_next;
      last_box_reg   <= last_box_next;
      last_valid_reg <= last_valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = DRAW;
      DRAW:    if (accept || last_try) state_next = DONE;
      DONE:    if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tries_next      = tries_reg;
    box_next        = box_reg;
    valid_next      = valid_reg;
    fallback_next   = fallback_reg;
    last_box_next   = last_box_reg;
    last_valid_next = last_valid_reg;
    case (state_reg)
      IDLE: begin
        if (req) tries_next = '0;
      end
      DRAW: begin
        if (accept) begin
          box_next      = cand;
          fallback_next = 1'b0;
          valid_next    = 1'b1;
        end else if (last_try) begin
          box_next      = fallback_box;
          fallback_next = 1'b1;
          valid_next    = 1'b1;
        end else begin
          tries_next = tries_reg + 8'd1;
        end
      end
      DONE: begin
        if (ack) begin
          valid_next      = 1'b0;
          last_box_next   = box_reg;
          last_valid_next = 1'b1;
        end
      end
      default: begin
        valid_next = 1'b0;
      end
    endcase
  end

  // One-hot copy is registered alongside box_idx and is zero whenever no result is held.
  generate
    for (gi = 0; gi < NUM_BOXES; gi++) begin : g_onehot
      assign onehot_next[gi] = valid_next && (box_next == IDX_W'(gi));
    end
  endgenerate

  assign valid      = valid_reg;
  assign box_idx    = box_reg;
  assign box_onehot = onehot_reg;
  assign fallback   = fallback_reg;
  assign lfsr_state = lfsr_reg;

endmodule

// File: tb/tb_mole_box_picker.sv
// Directed bench for mole_box_picker: a per-cycle vector table plus hand sequences for
// the LFSR period, reset mid-draw/mid-result, and a 3-box instance with a random run.
module tb_mole_box_picker;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk;
  logic       reset;
  logic       enable, seed_load, req, ack;
  logic [7:0] seed_in;
  logic       valid, fallback;
  logic [1:0] box_idx;
  logic [3:0] box_onehot;
  logic [7:0] lfsr_state;

  logic       en3, sl3, rq3, ak3;
  logic [7:0] seed3;
  logic       valid3, fb3;
  logic [1:0] box3;
  logic [2:0] onehot3;
  logic [7:0] lfsr3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       en;
    logic       sl;
    logic [7:0] seed;
    logic       rq;
    logic       ak;
    logic       ev;
    logic [1:0] eb;
    logic [3:0] eoh;
    logic       efb;
    logic [7:0] elfsr;
  } vec_t;

  vec_t       vecs[$];
  vec_t       cur;
  logic [7:0] hold_seq [10];
  logic [7:0] model;
  logic [2:0] exp_oh3;
  int         zero_seen, first_return, n, prev, dly;

  mole_box_picker u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .req       (req),
    .ack       (ack),
    .valid     (valid),
    .box_idx   (box_idx),
    .box_onehot(box_onehot),
    .fallback  (fallback),
    .lfsr_state(lfsr_state)
  );

  mole_box_picker #(.NUM_BOXES(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .enable    (en3),
    .seed_load (sl3),
    .seed_in   (seed3),
    .req       (rq3),
    .ack       (ak3),
    .valid     (valid3),
    .box_idx   (box3),
    .box_onehot(onehot3),
    .fallback  (fb3),
    .lfsr_state(lfsr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"},  valid,      0);
    check({tag, "_box"},    box_idx,    0);
    check({tag, "_onehot"}, box_onehot, 0);
    check({tag, "_fb"},     fallback,   0);
    check({tag, "_lfsr"},   lfsr_state, 8'h01);
  endtask

  function automatic logic [7:0] galois(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  function automatic vec_t mk(input logic en, input logic sl, input logic [7:0] seed,
                              input logic rq, input logic ak, input logic ev,
                              input logic [1:0] eb, input logic [3:0] eoh,
                              input logic efb, input logic [7:0] elfsr);
    vec_t v;
    v.en = en; v.sl = sl; v.seed = seed; v.rq = rq; v.ak = ak;
    v.ev = ev; v.eb = eb; v.eoh = eoh; v.efb = efb; v.elfsr = elfsr;
    return v;
  endfunction

  initial begin
    reset = H; enable = L; seed_load = L; seed_in = 8'h00; req = L; ack = L;
    en3 = L; sl3 = L; seed3 = 8'h00; rq3 = L; ak3 = L;

    // Cycle-by-cycle table starting right after reset (default parameters).
    hold_seq = '{8'h17, 8'hB3, 8'hE1, 8'hC8, 8'h64, 8'h32, 8'h19, 8'hB4, 8'h5A, 8'h2D};
    vecs.push_back(mk(H, L, 8'h00, L, L, L, 2'd0, 4'b0000, L, 8'hB8));
    vecs.push_back(mk(H, L, 8'h00, H, L, L, 2'd0, 4'b0000, L, 8'h5C));
    vecs.push_back(mk(H, L, 8'h00, L, L, H, 2'd0, 4'b0001, L, 8'h2E));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(H, L, 8'h00, (i == 0), L, H, 2'd0, 4'b0001, L, hold_seq[i]));
    vecs.push_back(mk(H, L, 8'h00, L, H, L, 2'd0, 4'b0000, L, 8'hAE));
    vecs.push_back(mk(H, L, 8'h00, L, L, L, 2'd0, 4'b0000, L, 8'h57));
    vecs.push_back(mk(L, H, 8'h5C, L, L, L, 2'd0, 4'b0000, L, 8'h5C));
    vecs.push_back(mk(L, L, 8'h00, H, L, L, 2'd0, 4'b0000, L, 8'h5C));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(L, L, 8'h00, L, L, L, 2'd0, 4'b0000, L, 8'h5C));
    vecs.push_back(mk(L, L, 8'h00, L, L, H, 2'd1, 4'b0010, H, 8'h5C));
    vecs.push_back(mk(L, L, 8'h00, L, H, L, 2'd0, 4'b0000, L, 8'h5C));
    vecs.push_back(mk(H, H, 8'h00, L, L, L, 2'd0, 4'b0000, L, 8'h01));
    vecs.push_back(mk(H, H, 8'h5C, L, L, L, 2'd0, 4'b0000, L, 8'h5C));
    vecs.push_back(mk(L, L, 8'h00, H, L, L, 2'd0, 4'b0000, L, 8'h5C));
    vecs.push_back(mk(L, L, 8'h00, L, L, H, 2'd0, 4'b0001, L, 8'h5C));
    vecs.push_back(mk(L, L, 8'h00, L, H, L, 2'd0, 4'b0000, L, 8'h5C));
    vecs.push_back(mk(L, L, 8'h00, H, L, L, 2'd0, 4'b0000, L, 8'h5C));
    vecs.push_back(mk(L, H, 8'h03, L, L, L, 2'd0, 4'b0000, L, 8'h03));
    vecs.push_back(mk(L, L, 8'h00, L, L, H, 2'd3, 4'b1000, L, 8'h03));
    vecs.push_back(mk(L, L, 8'h00, L, H, L, 2'd0, 4'b0000, L, 8'h03));
    vecs.push_back(mk(L, L, 8'h00, H, L, L, 2'd0, 4'b0000, L, 8'h03));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(L, L, 8'h00, L, L, L, 2'd0, 4'b0000, L, 8'h03));
    vecs.push_back(mk(L, L, 8'h00, L, L, H, 2'd0, 4'b0001, H, 8'h03));
    vecs.push_back(mk(L, L, 8'h00, H, H, L, 2'd0, 4'b0000, L, 8'h03));
    vecs.push_back(mk(L, L, 8'h00, L, H, L, 2'd0, 4'b0000, L, 8'h03));
    vecs.push_back(mk(L, L, 8'h00, L, L, L, 2'd0, 4'b0000, L, 8'h03));

    tick();
    tick();
    check_reset("reset");
    check("reset_dut3_valid", valid3, 0);
    check("reset_dut3_lfsr", lfsr3, 8'h01);
    reset = L;

    for (int i = 0; i < vecs.size(); i++) begin
      cur = vecs[i];
      enable = cur.en; seed_load = cur.sl; seed_in = cur.seed; req = cur.rq; ack = cur.ak;
      tick();
      check($sformatf("vec%0d_valid", i), valid, cur.ev);
      check($sformatf("vec%0d_onehot", i), box_onehot, cur.eoh);
      check($sformatf("vec%0d_lfsr", i), lfsr_state, cur.elfsr);
      if (cur.ev) begin
        check($sformatf("vec%0d_box", i), box_idx, cur.eb);
        check($sformatf("vec%0d_fb", i), fallback, cur.efb);
      end
      $display("vec %0d: en=%0d sl=%0d req=%0d ack=%0d -> valid=%0d box=%0d onehot=%b fb=%0d lfsr=%02h",
               i, cur.en, cur.sl, cur.rq, cur.ak, valid, box_idx, box_onehot, fallback, lfsr_state);
    end
    enable = L; seed_load = L; req = L; ack = L;

    // Full LFSR period from reset: 255 steps, never zero, first return to 01 at step 255.
    reset = H; tick(); reset = L; enable = H;
    model = 8'h01; zero_seen = 0; first_return = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      model = galois(model);
      check("lfsr_walk", lfsr_state, model);
      if (lfsr_state == 8'h00) zero_seen++;
      if (lfsr_state == 8'h01 && first_return == 0) first_return = i;
    end
    check("lfsr_zero_seen", zero_seen, 0);
    check("lfsr_period", first_return, 255);
    $display("lfsr walk: 255 steps, returned to 01 at step %0d", first_return);
    enable = L;

    // Reset while a result is held.
    req = H; tick(); req = L; tick();
    check("done_valid", valid, 1);
    check("done_box", box_idx, 1);
    check("done_onehot", box_onehot, 4'b0010);
    reset = H; tick(); reset = L;
    check_reset("rst_in_done");
    req = H; tick(); req = L; tick();
    check("after_done_rst_valid", valid, 1);
    check("after_done_rst_box", box_idx, 1);
    $display("reset in DONE: recovered valid=%0d box=%0d", valid, box_idx);
    ack = H; tick(); ack = L;
    check("after_done_rst_ack", valid, 0);

    // Reset mid-draw (last box 1 makes candidate 1 a repeat; reseed while drawing).
    req = H; tick(); req = L; seed_load = H; seed_in = 8'h5C; tick(); seed_load = L;
    check("draw_pending_valid", valid, 0);
    check("draw_reseed_lfsr", lfsr_state, 8'h5C);
    reset = H; tick(); reset = L;
    check_reset("rst_in_draw");
    req = H; tick(); req = L; tick();
    check("after_draw_rst_valid", valid, 1);
    check("after_draw_rst_fb", fallback, 0);
    check("after_draw_rst_box", box_idx, 1);
    $display("reset in DRAW: recovered valid=%0d box=%0d fb=%0d", valid, box_idx, fallback);
    ack = H; tick(); ack = L;

    // Three boxes: candidate 3 is out of range, so a frozen LFSR forces the fallback.
    sl3 = H; seed3 = 8'h03; tick(); sl3 = L;
    check("dut3_seed", lfsr3, 8'h03);
    rq3 = H; tick(); rq3 = L;
    n = 0;
    while (!valid3 && n < 20) begin
      tick();
      n++;
    end
    check("dut3_fb_latency", n, 8);
    check("dut3_fb_flag", fb3, 1);
    check("dut3_fb_box", box3, 0);
    check("dut3_fb_onehot", onehot3, 3'b001);
    $display("dut3 fallback: cycles=%0d box=%0d fb=%0d", n, box3, fb3);
    ak3 = H; tick(); ak3 = L;
    check("dut3_fb_ack", valid3, 0);

    en3 = H; prev = 0;
    for (int k = 0; k < 1000; k++) begin
      rq3 = H; tick(); rq3 = L;
      n = 0;
      while (!valid3 && n < 20) begin
        tick();
        n++;
      end
      check("dut3_rand_valid", valid3, 1);
      check("dut3_rand_latency", (n >= 1 && n <= 8), 1);
      check("dut3_rand_range", (box3 < 2'd3), 1);
      check("dut3_rand_norepeat", (int'(box3) != prev), 1);
      exp_oh3 = 3'b001 << box3;
      check("dut3_rand_onehot", onehot3, exp_oh3);
      if (fb3) check("dut3_rand_fb_box", box3, (prev + 1) % 3);
      $display("rand %0d: box=%0d fb=%0d cycles=%0d lfsr=%02h", k, box3, fb3, n, lfsr3);
      prev = int'(box3);
      dly = $urandom_range(0, 2);
      for (int d = 0; d < dly; d++) tick();
      ak3 = H; tick(); ak3 = L;
    end
    en3 = L;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
